// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the GCD job scheduler.
// Contents:
//   sched_state_e - scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   clog2         - ceiling log2, used to size tags, pointers and counters
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gcd_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// The winner is the first asserted request at or after rr_ptr, searching
// upward with wrap-around.
// Ports:
//   req        in  N_REQ         request vector
//   rr_ptr     in  clog2(N_REQ)  highest-priority index for this round
//   gnt_onehot out N_REQ         one-hot grant (all zero when no request)
//   gnt_idx    out clog2(N_REQ)  binary index of the grant
//   any        out 1             at least one request present
module rr_arbiter
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]        gnt_onehot,
    output logic [clog2(N_REQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int IDW = clog2(N_REQ);

    logic [N_REQ-1:0] sel_s;
    logic             hit_s;
    int               j_s;

    // Rotating priority search; modulo keeps the wrap correct for any N_REQ.
    always_comb begin
        gnt_idx = {IDW{1'b0}};
        any     = 1'b0;
        sel_s   = {N_REQ{1'b0}};
        hit_s   = 1'b0;
        j_s     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j_s     = (int'(rr_ptr) + k) % N_REQ;
            sel_s   = {{(N_REQ-1){1'b0}}, 1'b1} << j_s;
            hit_s   = ~any & (|(req & sel_s));
            gnt_idx = hit_s ? IDW'(j_s) : gnt_idx;
            any     = any | hit_s;
        end
        gnt_onehot = any ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : {N_REQ{1'b0}};
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one subtractive GCD core between N_REQ requesters.
// A round-robin winner's operands are latched and the core is started with
// a one-cycle pulse; the result is returned tagged on a valid/ready port.
// Zero operands are answered directly (the core would never finish) and a
// timeout turns a hung core into an error response.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req/a_in/b_in         requester levels and packed operands (i at [i*W +: W])
//   ack                   one-cycle one-hot acknowledge of the captured requester
//   core_start/core_a/b   start pulse and held operands to the core
//   core_done/core_result core completion (rising edge used) and result
//   rsp_valid/ready/id/data/err  tagged response, held until handshake
//   busy                  high whenever the FSM is not IDLE
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*W-1:0]      a_in,
    input  logic [N_REQ*W-1:0]      b_in,
    output logic [N_REQ-1:0]        ack,
    output logic                    core_start,
    output logic [W-1:0]            core_a,
    output logic [W-1:0]            core_b,
    input  logic                    core_done,
    input  logic [W-1:0]            core_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IDW = clog2(N_REQ);
    localparam int CW  = clog2(TIMEOUT + 1);
    // The counter is 0 in the first WAIT cycle, so firing on TIMEOUT-1 makes
    // the response appear exactly TIMEOUT cycles after WAIT was entered.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    sched_state_e     state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             core_start_q, core_start_d;
    logic [W-1:0]     core_a_q, core_a_d;
    logic [W-1:0]     core_b_q, core_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] arb_onehot_s;
    logic [IDW-1:0]   arb_idx_s;
    logic             arb_any_s;
    logic [W-1:0]     op_a_s;
    logic [W-1:0]     op_b_s;
    logic             done_rise_s;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .gnt_onehot (arb_onehot_s),
        .gnt_idx    (arb_idx_s),
        .any        (arb_any_s)
    );

    assign op_a_s      = W'(a_in >> (W * int'(arb_idx_s)));
    assign op_b_s      = W'(b_in >> (W * int'(arb_idx_s)));
    // A done level already high when WAIT is entered never looks like an edge.
    assign done_rise_s = core_done & ~done_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        ack_d      = {N_REQ{1'b0}};
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    ack_d    = arb_onehot_s;
                    core_a_d = op_a_s;
                    core_b_d = op_b_s;
                    rsp_id_d = arb_idx_s;
                    if ((op_a_s == {W{1'b0}}) || (op_b_s == {W{1'b0}})) begin
                        // gcd(x,0) = x and gcd(0,0) is reported as 0.
                        rsp_data_d = op_a_s | op_b_s;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = {CW{1'b0}};
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (done_rise_s) begin
                    rsp_data_d = core_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = {W{1'b0}};
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (rsp_id_q == IDW'(N_REQ - 1)) ? {IDW{1'b0}}
                                                             : (rsp_id_q + IDW'(1));
                    state_d  = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        core_start_d = (state_d == ISSUE);
        rsp_valid_d  = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= {IDW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            done_q       <= 1'b0;
            ack_q        <= {N_REQ{1'b0}};
            core_start_q <= 1'b0;
            core_a_q     <= {W{1'b0}};
            core_b_q     <= {W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= {IDW{1'b0}};
            rsp_data_q   <= {W{1'b0}};
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            done_q       <= core_done;
            ack_q        <= ack_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
`timescale 1ns/1ps
module tb_gcd_job_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TO  = 1023;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     ack;
    logic             core_start;
    logic [W-1:0]     core_a;
    logic [W-1:0]     core_b;
    logic             core_done;
    logic [W-1:0]     core_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    gcd_job_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int ptr_m = 0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    // Reference arithmetic: Euclid by remainder.
    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
        int p, q, t;
        p = int'(x);
        q = int'(y);
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    // Reference round-robin choice: first requester at or after p, with wrap.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (((m >> j) & 4'b0001) != 4'b0000) return j;
        end
        return -1;
    endfunction

    // Behavioural core: answers gcd of presented operands core_lat+1 edges after start.
    int          core_lat = 5;
    bit          core_hang = 1'b0;
    bit          core_level = 1'b0;
    int          core_cnt;
    logic [W-1:0] core_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0; core_result <= '0; core_cnt <= -1; core_pend <= '0;
        end else if (core_start) begin
            core_done <= 1'b0; core_cnt <= core_lat; core_pend <= gcd_f(core_a, core_b);
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (!core_level) core_done <= 1'b0;
        end else if (core_cnt == 0) begin
            core_cnt <= -1;
            if (!core_hang) begin core_done <= 1'b1; core_result <= core_pend; end
        end else if (!core_level) begin
            core_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a;
        opb[i] = b;
        a_in = '0;
        b_in = '0;
        for (int j = 0; j < N; j++) begin
            a_in = a_in | ((N*W)'(opa[j]) << (j*W));
            b_in = b_in | ((N*W)'(opb[j]) << (j*W));
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, 32'({ack, core_start, rsp_valid, rsp_id, rsp_err, busy}), 32'd0);
        chk({nm, "_data"}, 32'({core_a, core_b, rsp_data}), 32'd0);
    endtask

    // Follows one job from the IDLE sample to its response handshake.
    task automatic run_job(input string nm, input int exp_id, input logic [W-1:0] ea,
                           input logic [W-1:0] eb, input logic [W-1:0] edata, input bit eerr,
                           input int rdly, input bit drop, output int lat);
        int cyc, acks, ack_id, starts, s_cyc;
        logic [IDW+W:0] snap;
        bit bad;
        cyc = 0; acks = 0; ack_id = -1; starts = 0; s_cyc = 0; lat = -1; bad = 1'b0;
        while (!rsp_valid && cyc < TO + 64) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                acks++;
                for (int i = 0; i < N; i++) begin
                    if (((ack >> i) & 4'b0001) != 4'b0000) begin
                        ack_id = i;
                        if (drop) req = req & ~(N'(1) << i);
                    end
                end
                chk({nm, "_ack_onehot"}, $countones(ack), 32'd1);
            end
            if (core_start) begin
                starts++;
                s_cyc = cyc;
                chk({nm, "_ack_with_start"}, 32'(ack != '0), 32'd1);
                chk({nm, "_core_a"}, 32'(core_a), 32'(ea));
                chk({nm, "_core_b"}, 32'(core_b), 32'(eb));
            end
        end
        if (!rsp_valid) begin
            chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        lat = cyc - s_cyc;
        chk({nm, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({nm, "_data"}, 32'(rsp_data), 32'(edata));
        chk({nm, "_err"}, 32'(rsp_err), 32'(eerr));
        chk({nm, "_acks"}, 32'(acks), 32'd1);
        chk({nm, "_ack_id"}, 32'(ack_id), 32'(exp_id));
        chk({nm, "_starts"}, 32'(starts), (ea != '0 && eb != '0) ? 32'd1 : 32'd0);
        snap = {rsp_id, rsp_data, rsp_err};
        for (int d = 0; d < rdly; d++) begin
            @(negedge clk);
            if (!rsp_valid || ({rsp_id, rsp_data, rsp_err} !== snap) || ack != '0) bad = 1'b1;
        end
        if (rdly > 0) chk({nm, "_hold"}, 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        ptr_m = (exp_id + 1) % N;
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs [9];
    int   fair_exp [6];

    initial begin
        int lat, w, other;
        logic [N-1:0] mask;
        logic [W-1:0] ra, rb;

        vecs[0] = '{0, 8'd48,  8'd18,  20, 8'd6};
        vecs[1] = '{2, 8'd0,   8'd25,  3,  8'd25};
        vecs[2] = '{1, 8'd0,   8'd0,   3,  8'd0};
        vecs[3] = '{3, 8'd35,  8'd21,  4,  8'd7};
        vecs[4] = '{1, 8'd255, 8'd17,  2,  8'd17};
        vecs[5] = '{2, 8'd1,   8'd255, 1,  8'd1};
        vecs[6] = '{0, 8'd200, 8'd0,   5,  8'd200};
        vecs[7] = '{3, 8'd128, 8'd96,  6,  8'd32};
        vecs[8] = '{2, 8'd13,  8'd13,  0,  8'd13};
        fair_exp = '{0, 1, 2, 3, 0, 1};

        req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness with all requests held, then a reduced request set.
        set_op(0, 8'd12, 8'd8); set_op(1, 8'd9, 8'd6);
        set_op(2, 8'd10, 8'd4); set_op(3, 8'd21, 8'd14);
        core_lat = 2;
        req = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            w = fair_exp[s];
            chk("fair_model", 32'(pick(req, ptr_m)), 32'(w));
            run_job("fair", w, opa[w], opb[w], gcd_f(opa[w], opb[w]), 1'b0, 0, 1'b0, lat);
        end
        req = 4'b1010;
        run_job("fair_1010_a", 3, opa[3], opb[3], 8'd7, 1'b0, 0, 1'b0, lat);
        run_job("fair_1010_b", 1, opa[1], opb[1], 8'd3, 1'b0, 0, 1'b0, lat);
        req = '0;

        // Vector table: single-requester jobs including zero operands.
        for (int v = 0; v < 9; v++) begin
            core_lat = vecs[v].lat;
            core_level = (v % 2) == 1;
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            req = N'(1) << vecs[v].id;
            run_job("vec", vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp_data, 1'b0, 0, 1'b1, lat);
            if (vecs[v].a != '0 && vecs[v].b != '0) chk("vec_latency", 32'(lat), 32'(vecs[v].lat + 3));
            req = '0;
        end
        core_level = 1'b0;

        // Hung core: error response after the timeout, then normal service.
        core_hang = 1'b1;
        set_op(2, 8'd60, 8'd45);
        req = 4'b0100;
        run_job("hung", 2, 8'd60, 8'd45, 8'd0, 1'b1, 0, 1'b1, lat);
        chk("hung_latency", 32'(lat), 32'(TO + 1));
        core_hang = 1'b0;
        core_lat = 4;
        req = 4'b0100;
        run_job("after_hung", 2, 8'd60, 8'd45, 8'd15, 1'b0, 0, 1'b1, lat);
        chk("after_hung_latency", 32'(lat), 32'd7);
        req = '0;

        // Backpressure with a second request pending.
        set_op(0, 8'd84, 8'd36); set_op(2, 8'd77, 8'd33);
        req = 4'b0101;
        w = pick(4'b0101, ptr_m);
        other = (w == 0) ? 2 : 0;
        run_job("bp", w, opa[w], opb[w], gcd_f(opa[w], opb[w]), 1'b0, 10, 1'b1, lat);
        run_job("bp_next", other, opa[other], opb[other], gcd_f(opa[other], opb[other]),
                1'b0, 0, 1'b1, lat);
        req = '0;

        // Randomized jobs against the reference model.
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                ra = W'($urandom_range(0, 255));
                rb = W'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) ra = '0;
                if ($urandom_range(0, 7) == 0) rb = '0;
                set_op(i, ra, rb);
            end
            core_lat = $urandom_range(0, 12);
            core_level = $urandom_range(0, 1) == 1;
            req = mask;
            w = pick(mask, ptr_m);
            run_job("rand", w, opa[w], opb[w], gcd_f(opa[w], opb[w]), 1'b0,
                    $urandom_range(0, 3), 1'b1, lat);
            if (opa[w] != '0 && opb[w] != '0) chk("rand_latency", 32'(lat), 32'(core_lat + 3));
            req = '0;
        end
        core_level = 1'b0;

        // Reset in the middle of WAIT.
        core_lat = 40;
        set_op(3, 8'd100, 8'd75);
        req = 4'b1000;
        repeat (6) @(negedge clk);
        chk("midwait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midwait_reset");
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        core_lat = 3;
        set_op(1, 8'd35, 8'd21);
        req = 4'b0010;
        run_job("after_reset", 1, 8'd35, 8'd21, 8'd7, 1'b0, 0, 1'b1, lat);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
